xor_parity_seq: RTL and testbench

//   Sequential parity controller built around one shared xor_3 instance.

---
 rtl/xor_parity_seq.sv | 104 ++++++++++
 tb/tb_xor_parity_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/xor_parity_seq.sv
// Sequential parity generator/checker: folds a DATA_W-bit word two bits per
// cycle through one shared three-input XOR. Words arrive and results leave on
// valid/ready handshakes.

module xor_3 (
  input  logic in0,
  input  logic in1,
  input  logic in2,
  output logic o_res
);

  assign o_res = in0 ^ in1 ^ in2;

endmodule

module xor_parity_seq #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_odd,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_parity,
  output logic              o_busy
);

  localparam int unsigned PAIRS = DATA_W / 2;
  localparam int unsigned CNT_W = $clog2(PAIRS + 1);

  if ((DATA_W < 2) || ((DATA_W % 2) != 0)) begin : g_bad_width
    $fatal(1, "xor_parity_seq: DATA_W must be even and >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] sh;
  logic              acc;
  logic [CNT_W-1:0]  cnt;
  logic              fold;

  // The single shared fold stage: accumulator combined with the low bit pair.
  xor_3 u_xor_3 (
    .in0   (acc),
    .in1   (sh[0]),
    .in2   (sh[1]),
    .o_res (fold)
  );

  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      sh       <= '0;
      acc      <= 1'b0;
      cnt      <= '0;
      o_valid  <= 1'b0;
      o_parity <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            sh    <= i_data;
            acc   <= i_odd;
            cnt   <= CNT_W'(PAIRS);
            state <= RUN;
          end
        end
        RUN: begin
          acc <= fold;
          sh  <= sh >> 2;
          cnt <= cnt - CNT_W'(1);
          // Last pair: publish the folded result straight from the XOR stage.
          if (cnt == CNT_W'(1)) begin
            o_parity <= fold;
            o_valid  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_parity_seq.sv
// Bench for xor_parity_seq: directed checks on an 8-bit instance plus random
// traffic on 2/8/16-bit instances checked against a transaction-level model.

module tb_xor_parity_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed 8-bit instance ----------------
  logic       d_rst_n = 1'b0;
  logic       d_valid = 1'b0;
  logic       d_odd   = 1'b0;
  logic       d_ready = 1'b1;
  logic [7:0] d_data  = 8'h00;
  logic       d_oready, d_ovalid, d_par, d_busy;
  bit         d_done  = 1'b0;

  xor_parity_seq #(.DATA_W(8)) u_dut_dir (
    .i_clk    (clk),
    .i_rst_n  (d_rst_n),
    .i_valid  (d_valid),
    .o_ready  (d_oready),
    .i_data   (d_data),
    .i_odd    (d_odd),
    .o_valid  (d_ovalid),
    .i_ready  (d_ready),
    .o_parity (d_par),
    .o_busy   (d_busy)
  );

  // Present one word, then wait (bounded) for the result and check latency.
  task automatic d_send(input logic [7:0] data, input logic odd, input logic exp_par,
                        input string tag);
    int lat;
    @(negedge clk);
    d_valid = 1'b1;
    d_data  = data;
    d_odd   = odd;
    @(posedge clk); #1;
    d_valid = 1'b0;
    lat = 0;
    while (!d_ovalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " parity"}, 32'(d_par), 32'(exp_par));
  endtask

  task automatic d_release(input string tag);
    @(negedge clk);
    d_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " valid after hs"}, 32'(d_ovalid), 32'd0);
    check({tag, " ready after hs"}, 32'(d_oready), 32'd1);
  endtask

  logic [7:0] c_data [5] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h00};
  logic       c_odd  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       c_exp  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    #1;
    check("rst ready", 32'(d_oready), 32'd1);
    check("rst valid", 32'(d_ovalid), 32'd0);
    check("rst parity", 32'(d_par), 32'd0);
    check("rst busy", 32'(d_busy), 32'd0);
    #20;
    check("rst held ready", 32'(d_oready), 32'd1);
    @(negedge clk);
    d_rst_n = 1'b1;

    d_send(8'hB5, 1'b0, 1'b1, "B5 even");
    d_release("B5 even");
    d_send(8'hB5, 1'b1, 1'b0, "B5 odd");
    d_release("B5 odd");

    // Result held under backpressure; input pulses in DONE must be ignored.
    d_ready = 1'b0;
    d_send(8'h3C, 1'b0, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d_valid = (i % 2 == 0);
      d_data  = 8'hFF;
      d_odd   = 1'b1;
      @(posedge clk); #1;
      check($sformatf("bp valid %0d", i), 32'(d_ovalid), 32'd1);
      check($sformatf("bp parity %0d", i), 32'(d_par), 32'd0);
      check($sformatf("bp ready %0d", i), 32'(d_oready), 32'd0);
    end
    @(negedge clk);
    d_valid = 1'b0;
    d_release("bp");
    repeat (3) begin
      @(posedge clk); #1;
      check("bp no spurious", 32'(d_ovalid), 32'd0);
    end

    for (int i = 0; i < 5; i++) begin
      d_send(c_data[i], c_odd[i], c_exp[i], $sformatf("corner%0d", i));
      d_release($sformatf("corner%0d", i));
    end

    // Reset during RUN drops the word (o_parity is 1 beforehand).
    @(negedge clk);
    d_valid = 1'b1;
    d_data  = 8'hA7;
    d_odd   = 1'b0;
    @(posedge clk); #1;
    d_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    d_rst_n = 1'b0;
    #1;
    check("midrst ready", 32'(d_oready), 32'd1);
    check("midrst valid", 32'(d_ovalid), 32'd0);
    check("midrst parity", 32'(d_par), 32'd0);
    check("midrst busy", 32'(d_busy), 32'd0);
    @(negedge clk);
    d_rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("midrst no valid", 32'(d_ovalid), 32'd0);
    end
    d_send(8'h81, 1'b1, 1'b1, "post rst");
    d_release("post rst");
    d_done = 1'b1;
  end

  // ---------------- random instances: DATA_W = 2, 8, 16 ----------------
  logic r_rst_n = 1'b0;

  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int unsigned W = (g == 0) ? 2 : ((g == 1) ? 8 : 16);

    logic         valid = 1'b0;
    logic         odd   = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] data  = '0;
    logic         oready, ovalid, par, busy;

    int unsigned cyc      = 0;
    int unsigned accepted = 0;
    int unsigned acc_edge = 0;
    bit          inflight = 1'b0;
    bit          exp_par  = 1'b0;
    bit          exp_valid;
    bit          done     = 1'b0;

    xor_parity_seq #(.DATA_W(W)) u_dut (
      .i_clk    (clk),
      .i_rst_n  (r_rst_n),
      .i_valid  (valid),
      .o_ready  (oready),
      .i_data   (data),
      .i_odd    (odd),
      .o_valid  (ovalid),
      .i_ready  (ready),
      .o_parity (par),
      .o_busy   (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
      @(posedge r_rst_n);
      forever begin
        @(posedge clk); #2;
        valid = (accepted < 500) && ($urandom_range(0, 9) < 6);
        data  = W'($urandom);
        odd   = 1'($urandom);
        ready = ($urandom_range(0, 9) < 7);
      end
    end

    // Transaction model: one word in flight, result due W/2 edges after accept.
    always @(negedge clk) begin
      if (r_rst_n && !done) begin
        exp_valid = inflight && (cyc >= acc_edge + W / 2);
        check($sformatf("W%0d ready", W), 32'(oready), 32'(!inflight));
        check($sformatf("W%0d busy", W), 32'(busy), 32'(inflight));
        check($sformatf("W%0d valid", W), 32'(ovalid), 32'(exp_valid));
        if (exp_valid)
          check($sformatf("W%0d parity word %0d", W, accepted), 32'(par), 32'(exp_par));
        if (!inflight && valid) begin
          inflight = 1'b1;
          acc_edge = cyc + 1;
          exp_par  = odd ^ 1'($countones(data) & 1);
          accepted++;
        end else if (exp_valid && ready) begin
          inflight = 1'b0;
          if (accepted >= 500) done = 1'b1;
        end
      end
    end
  end

  initial begin
    #22;
    r_rst_n = 1'b1;
    for (int i = 0; i < 60000; i++) begin
      if (d_done && g_rnd[0].done && g_rnd[1].done && g_rnd[2].done) break;
      @(posedge clk);
    end
    if (!(d_done && g_rnd[0].done && g_rnd[1].done && g_rnd[2].done)) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: done flags dir=%0d w2=%0d w8=%0d w16=%0d required all 1",
               d_done, g_rnd[0].done, g_rnd[1].done, g_rnd[2].done);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
